// File: rtl/pc_sequencer_if.sv
// Fetch-path bundle between the pipeline front end and the next-PC sequencer.
// The master side drives PC and control requests. The slave side returns the next address and interrupt status.
interface pc_sequencer_if #(
   parameter int DATA_W = 32
);
   logic [1:0]        prog_sel;
   logic [DATA_W-1:0] pc;
   logic              stall;
   logic              branch_taken;
   logic [DATA_W-1:0] branch_target;
   logic              jump;
   logic [DATA_W-1:0] jump_target;
   logic              eret;
   logic              halt;
   logic              interrupt;
   logic              int_mask;
   logic [DATA_W-1:0] next_address;
   logic [DATA_W-1:0] epc;
   logic              in_isr;
   logic              halted;
   logic              irq_ack;
   logic [1:0]        seq_state;

   modport master (
      output prog_sel, pc, stall, branch_taken, branch_target, jump, jump_target,
             eret, halt, interrupt, int_mask,
      input  next_address, epc, in_isr, halted, irq_ack, seq_state
   );

   modport slave (
      input  prog_sel, pc, stall, branch_taken, branch_target, jump, jump_target,
             eret, halt, interrupt, int_mask,
      output next_address, epc, in_isr, halted, irq_ack, seq_state
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch path. It selects the program counter's load address each cycle.
// It also owns interrupt entry/return sequencing, the EPC register and the reset program vector.
module pc_sequencer #(
   parameter int DATA_W     = 32,
   parameter int PC_STEP    = 1,
   parameter int PROG0_BASE = 0,
   parameter int PROG1_BASE = 15,
   parameter int PROG2_BASE = 30,
   parameter int IRQ_VECTOR = 60
) (
   input  logic           clock,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {
      RUN  = 2'b00,
      ISR  = 2'b01,
      HALT = 2'b10
   } state_t;

   localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);
   localparam logic [DATA_W-1:0] VEC  = DATA_W'(IRQ_VECTOR);

   state_t            state, next_state;
   logic              irq_pending;
   logic              interrupt_d;
   logic [DATA_W-1:0] epc_r;
   logic              irq_ack_r;

   logic              rise;
   logic              take;
   logic [DATA_W-1:0] norm;
   logic [DATA_W-1:0] nxt;
   logic [DATA_W-1:0] epc_val;

   function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] p);
      return p + STEP;
   endfunction

   // prog_sel 10 deliberately aliases program 0
   function automatic logic [DATA_W-1:0] reset_base(input logic [1:0] sel);
      case (sel)
         2'b01:   return DATA_W'(PROG1_BASE);
         2'b11:   return DATA_W'(PROG2_BASE);
         default: return DATA_W'(PROG0_BASE);
      endcase
   endfunction

   assign rise = bus.interrupt & ~interrupt_d;
   assign norm = bus.jump         ? bus.jump_target   :
                 bus.branch_taken ? bus.branch_target :
                 bus.stall        ? bus.pc            : pc_inc(bus.pc);

   always_comb begin
      next_state = state;
      nxt        = norm;
      take       = 1'b0;
      epc_val    = norm;
      if (reset) begin
         nxt = reset_base(bus.prog_sel);
      end else begin
         case (state)
            RUN: begin
               if (bus.halt) begin
                  nxt        = bus.pc;
                  next_state = HALT;
               end else if (irq_pending & ~bus.int_mask & ~bus.stall) begin
                  nxt        = VEC;
                  take       = 1'b1;
                  next_state = ISR;
               end
            end
            ISR: begin
               if (bus.halt) begin
                  nxt        = bus.pc;
                  next_state = HALT;
               end else if (bus.eret & ~bus.stall) begin
                  nxt        = epc_r;
                  next_state = RUN;
               end else if (bus.eret) begin
                  nxt = bus.pc;
               end
            end
            HALT: begin
               nxt = bus.pc;
               if (irq_pending & ~bus.int_mask) begin
                  nxt        = VEC;
                  epc_val    = pc_inc(bus.pc);
                  take       = 1'b1;
                  next_state = ISR;
               end
            end
            default: next_state = RUN;
         endcase
      end
   end

   // a rise landing in the take cycle keeps a fresh request pending
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= RUN;
         irq_pending <= 1'b0;
         interrupt_d <= 1'b0;
         epc_r       <= '0;
         irq_ack_r   <= 1'b0;
      end else begin
         state       <= next_state;
         interrupt_d <= bus.interrupt;
         irq_pending <= rise | (irq_pending & ~take);
         irq_ack_r   <= take;
         if (take) epc_r <= epc_val;
      end
   end

   assign bus.next_address = nxt;
   assign bus.epc          = epc_r;
   assign bus.irq_ack      = irq_ack_r;
   assign bus.in_isr       = (state == ISR);
   assign bus.halted       = (state == HALT);
   assign bus.seq_state    = state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer: each record is one clock cycle of stimulus
// with its hand-computed outputs, followed by a short hand-written irq_ack pulse-width sequence.
module tb_pc_sequencer;
   logic clock = 1'b0;
   logic reset = 1'b1;

   pc_sequencer_if #(.DATA_W(32)) bus ();

   pc_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic [1:0]  sel;
      logic [31:0] pc;
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        j;
      logic [31:0] jt;
      logic        eret;
      logic        halt;
      logic        irq;
      logic        mask;
      logic [31:0] na;
      logic [31:0] epc;
      logic [1:0]  st;
      logic        ack;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(logic rst, logic [1:0] sel, logic [31:0] pc, logic stall,
                               logic br, logic [31:0] bt, logic j, logic [31:0] jt,
                               logic eret, logic halt, logic irq, logic mask,
                               logic [31:0] na, logic [31:0] epc, logic [1:0] st, logic ack);
      vec_t v;
      v.rst = rst; v.sel = sel; v.pc = pc; v.stall = stall; v.br = br; v.bt = bt;
      v.j = j; v.jt = jt; v.eret = eret; v.halt = halt; v.irq = irq; v.mask = mask;
      v.na = na; v.epc = epc; v.st = st; v.ack = ack;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset                = v.rst;
      bus.prog_sel         = v.sel;
      bus.pc               = v.pc;
      bus.stall            = v.stall;
      bus.branch_taken     = v.br;
      bus.branch_target    = v.bt;
      bus.jump             = v.j;
      bus.jump_target      = v.jt;
      bus.eret             = v.eret;
      bus.halt             = v.halt;
      bus.interrupt        = v.irq;
      bus.int_mask         = v.mask;
   endtask

   initial begin
      int acks;
      //        rst sel    pc   stl br  bt  j  jt   er hl irq mk   na   epc st    ack
      vecs.push_back(mk(1, 2'b01,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0,  15,  0, 2'b00, 0));
      vecs.push_back(mk(1, 2'b00,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0,   0,  0, 2'b00, 0));
      vecs.push_back(mk(1, 2'b10,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0,   0,  0, 2'b00, 0));
      vecs.push_back(mk(1, 2'b11,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0,  30,  0, 2'b00, 0));
      vecs.push_back(mk(1, 2'b01,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0,  15,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b01, 15, 0, 0,  0, 0,   0, 0, 0, 0, 0,  16,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 20, 0, 1, 64, 1, 128, 0, 0, 0, 0, 128,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 20, 0, 1, 64, 0,   0, 0, 0, 0, 0,  64,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 20, 1, 0,  0, 0,   0, 0, 0, 0, 0,  20,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 20, 1, 1, 64, 0,   0, 0, 0, 0, 0,  64,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 20, 0, 0,  0, 0,   0, 1, 0, 0, 0,  21,  0, 2'b00, 0));
      // interrupt entry from a branching cycle
      vecs.push_back(mk(0, 2'b00, 20, 0, 1, 64, 0,   0, 0, 0, 1, 0,  64,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 20, 0, 1, 64, 0,   0, 0, 0, 1, 0,  60,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 60, 0, 0,  0, 0,   0, 0, 0, 1, 0,  61, 64, 2'b01, 1));
      vecs.push_back(mk(0, 2'b00, 61, 0, 0,  0, 0,   0, 0, 0, 0, 0,  62, 64, 2'b01, 0));
      // rise during ISR stays pending, taken right after eret
      vecs.push_back(mk(0, 2'b00, 62, 0, 0,  0, 0,   0, 0, 0, 1, 0,  63, 64, 2'b01, 0));
      vecs.push_back(mk(0, 2'b00, 63, 0, 0,  0, 0,   0, 1, 0, 1, 0,  64, 64, 2'b01, 0));
      vecs.push_back(mk(0, 2'b00, 64, 0, 0,  0, 0,   0, 0, 0, 1, 0,  60, 64, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 60, 0, 0,  0, 0,   0, 0, 0, 0, 0,  61, 65, 2'b01, 1));
      vecs.push_back(mk(0, 2'b00, 61, 1, 0,  0, 0,   0, 1, 0, 0, 0,  61, 65, 2'b01, 0));
      vecs.push_back(mk(0, 2'b00, 61, 0, 0,  0, 0,   0, 1, 0, 0, 0,  65, 65, 2'b01, 0));
      vecs.push_back(mk(0, 2'b00, 65, 0, 0,  0, 0,   0, 0, 0, 0, 0,  66, 65, 2'b00, 0));
      // halt, masked wake-up, then unmasked vector
      vecs.push_back(mk(0, 2'b00, 33, 0, 0,  0, 0,   0, 0, 1, 0, 0,  33, 65, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 33, 1, 1, 64, 1, 128, 1, 0, 0, 0,  33, 65, 2'b10, 0));
      vecs.push_back(mk(0, 2'b00, 33, 0, 0,  0, 0,   0, 0, 0, 1, 1,  33, 65, 2'b10, 0));
      vecs.push_back(mk(0, 2'b00, 33, 0, 0,  0, 0,   0, 0, 0, 1, 1,  33, 65, 2'b10, 0));
      vecs.push_back(mk(0, 2'b00, 33, 0, 0,  0, 0,   0, 0, 0, 0, 0,  60, 65, 2'b10, 0));
      vecs.push_back(mk(0, 2'b00, 60, 0, 0,  0, 0,   0, 0, 0, 0, 0,  61, 34, 2'b01, 1));
      vecs.push_back(mk(0, 2'b00, 61, 0, 0,  0, 0,   0, 0, 1, 0, 0,  61, 34, 2'b01, 0));
      vecs.push_back(mk(0, 2'b00, 61, 0, 0,  0, 0,   0, 0, 0, 0, 0,  61, 34, 2'b10, 0));
      // reset out of HALT, then pending interrupt held off by stall
      vecs.push_back(mk(1, 2'b00, 61, 0, 0,  0, 0,   0, 0, 0, 0, 0,   0, 34, 2'b10, 0));
      vecs.push_back(mk(0, 2'b00,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0,   1,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00,  1, 1, 0,  0, 0,   0, 0, 0, 1, 0,   1,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00,  1, 1, 0,  0, 0,   0, 0, 0, 1, 0,   1,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00,  1, 1, 0,  0, 0,   0, 0, 0, 0, 0,   1,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00,  1, 0, 0,  0, 0,   0, 0, 0, 0, 0,  60,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 60, 0, 0,  0, 0,   0, 0, 0, 0, 0,  61,  2, 2'b01, 1));
      // reset in ISR with a pending request drops it
      vecs.push_back(mk(0, 2'b00, 61, 0, 0,  0, 0,   0, 0, 0, 1, 0,  62,  2, 2'b01, 0));
      vecs.push_back(mk(1, 2'b11, 62, 0, 0,  0, 0,   0, 0, 0, 0, 0,  30,  2, 2'b01, 0));
      vecs.push_back(mk(0, 2'b11, 30, 0, 0,  0, 0,   0, 0, 0, 0, 0,  31,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b11, 31, 0, 0,  0, 0,   0, 0, 0, 0, 0,  32,  0, 2'b00, 0));
      // rise in the take cycle survives as a new pending request
      vecs.push_back(mk(0, 2'b00, 32, 0, 0,  0, 0,   0, 0, 0, 1, 0,  33,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 33, 1, 0,  0, 0,   0, 0, 0, 0, 0,  33,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 33, 0, 0,  0, 0,   0, 0, 0, 1, 0,  60,  0, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 60, 0, 0,  0, 0,   0, 0, 0, 1, 0,  61, 34, 2'b01, 1));
      vecs.push_back(mk(0, 2'b00, 61, 0, 0,  0, 0,   0, 1, 0, 0, 0,  34, 34, 2'b01, 0));
      vecs.push_back(mk(0, 2'b00, 34, 0, 0,  0, 0,   0, 0, 0, 0, 0,  60, 34, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 60, 0, 0,  0, 0,   0, 0, 0, 0, 0,  61, 35, 2'b01, 1));
      // int_mask holds off a pending request in RUN
      vecs.push_back(mk(0, 2'b00, 61, 0, 0,  0, 0,   0, 1, 0, 0, 0,  35, 35, 2'b01, 0));
      vecs.push_back(mk(0, 2'b00, 35, 0, 0,  0, 0,   0, 0, 0, 1, 1,  36, 35, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 36, 0, 0,  0, 0,   0, 0, 0, 1, 1,  37, 35, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 37, 0, 0,  0, 0,   0, 0, 0, 0, 0,  60, 35, 2'b00, 0));
      vecs.push_back(mk(0, 2'b00, 60, 0, 0,  0, 0,   0, 0, 0, 0, 0,  61, 38, 2'b01, 1));

      drive(vecs[0]);
      repeat (2) @(posedge clock);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i]);
         #4;
         chk("next_address", i, bus.next_address, vecs[i].na);
         chk("epc",          i, bus.epc,          vecs[i].epc);
         chk("seq_state",    i, 32'(bus.seq_state), 32'(vecs[i].st));
         chk("irq_ack",      i, 32'(bus.irq_ack),   32'(vecs[i].ack));
         chk("in_isr",       i, 32'(bus.in_isr),    32'(vecs[i].st == 2'b01));
         chk("halted",       i, 32'(bus.halted),    32'(vecs[i].st == 2'b10));
         @(posedge clock);
         #1;
      end

      // irq_ack must be a single-cycle pulse for one take
      bus.pc   = 61;
      bus.eret = 1'b1;
      @(posedge clock);
      #1;
      bus.eret      = 1'b0;
      bus.pc        = 10;
      bus.interrupt = 1'b1;
      acks = 0;
      for (int k = 0; k < 8; k++) begin
         #4;
         if (bus.irq_ack === 1'b1) acks++;
         @(posedge clock);
         #1;
         bus.interrupt = 1'b0;
      end
      chk("ack_pulse_count", 0, 32'(acks), 32'd1);
      chk("ack_seq_state",   0, 32'(bus.seq_state), 32'd1);
      chk("ack_seq_epc",     0, bus.epc, 32'd11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
